sha1_round_core: RTL and testbench



---
 rtl/sha1_round_core.sv | 171 +++++++++++++++++
 tb/tb_sha1_round_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_round_core.sv
// sha1_round_core
// SHA-1 compression datapath: consumes the streamed W_t words, runs the 80
// rounds on working registers a..e, then folds a..e into the chaining
// state H0..H4. The digest, busy, done and seq_err outputs are all driven
// straight from registers.

module sha1_round_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first_block,
    input  logic [31:0]  w_in,
    input  logic [7:0]   round_in,
    input  logic         w_valid,
    output logic [159:0] digest,
    output logic         busy,
    output logic         done,
    output logic         seq_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUNDS = 2'd1,
        S_FINAL  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [6:0]   LAST_ROUND = 7'd79;

    state_t      state_q;
    logic [31:0] h_q [5];
    logic [31:0] a_q, b_q, c_q, d_q, e_q;
    logic [6:0]  t_q;
    logic        busy_q;
    logic        done_q;
    logic        seq_err_q;

    // Per-word views of the IV, the working registers and the FINAL sums.
    logic [31:0] iv_w   [5];
    logic [31:0] work_w [5];
    logic [31:0] h_sum_w[5];

    assign work_w[0] = a_q;
    assign work_w[1] = b_q;
    assign work_w[2] = c_q;
    assign work_w[3] = d_q;
    assign work_w[4] = e_q;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_words
            assign iv_w[gi]                   = IV[159-32*gi -: 32];
            assign h_sum_w[gi]                = h_q[gi] + work_w[gi];
            assign digest[159-32*gi -: 32]    = h_q[gi];
        end
    endgenerate

    // Round function, constant and the five-operand sum for the current t.
    logic [31:0] f_d;
    logic [31:0] k_d;
    logic [31:0] t_sum_d;
    logic [7:0]  tag_exp_d;
    logic        tag_ok_d;

    // Select f_t / K_t by round group and form T for this round.
    always_comb begin
        f_d = 32'h0;
        k_d = 32'h0;
        if (t_q < 7'd20) begin
            f_d = (b_q & c_q) | (~b_q & d_q);
            k_d = 32'h5A827999;
        end else if (t_q < 7'd40) begin
            f_d = b_q ^ c_q ^ d_q;
            k_d = 32'h6ED9EBA1;
        end else if (t_q < 7'd60) begin
            f_d = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k_d = 32'h8F1BBCDC;
        end else begin
            f_d = b_q ^ c_q ^ d_q;
            k_d = 32'hCA62C1D6;
        end
        t_sum_d = {a_q[26:0], a_q[31:27]} + f_d + e_q + k_d + w_in;
    end

    // The schedule block tags word W_t with t+2; anything else is out of
    // sequence (warm-up words, tail tags or a genuine slip).
    assign tag_exp_d = {1'b0, t_q} + 8'd2;
    assign tag_ok_d  = (round_in == tag_exp_d);

    // Main control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 5; i++) begin
                h_q[i] <= iv_w[i];
            end
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            c_q       <= 32'h0;
            d_q       <= 32'h0;
            e_q       <= 32'h0;
            t_q       <= 7'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (first_block) begin
                            for (int i = 0; i < 5; i++) begin
                                h_q[i] <= iv_w[i];
                            end
                            a_q <= iv_w[0];
                            b_q <= iv_w[1];
                            c_q <= iv_w[2];
                            d_q <= iv_w[3];
                            e_q <= iv_w[4];
                        end else begin
                            a_q <= h_q[0];
                            b_q <= h_q[1];
                            c_q <= h_q[2];
                            d_q <= h_q[3];
                            e_q <= h_q[4];
                        end
                        t_q       <= 7'd0;
                        seq_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ROUNDS;
                    end
                end
                S_ROUNDS: begin
                    // w_valid low is a stall: nothing moves, no timeout.
                    if (w_valid) begin
                        if (tag_ok_d) begin
                            e_q <= d_q;
                            d_q <= c_q;
                            c_q <= {b_q[1:0], b_q[31:2]};
                            b_q <= a_q;
                            a_q <= t_sum_d;
                            t_q <= t_q + 7'd1;
                            if (t_q == LAST_ROUND) begin
                                state_q <= S_FINAL;
                            end
                        end else begin
                            seq_err_q <= 1'b1;
                        end
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 5; i++) begin
                        h_q[i] <= h_sum_w[i];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_sha1_round_core.sv
// tb_sha1_round_core
// Scoreboard bench: the driver streams schedule words, pushes the expected
// digest / seq_err / done cycle computed by a plain SHA-1 model, and an
// independent monitor pops and compares whenever done pulses.

module tb_sha1_round_core;

    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         first_block = 1'b0;
    logic [31:0]  w_in = 32'h0;
    logic [7:0]   round_in = 8'h0;
    logic         w_valid = 1'b0;
    logic [159:0] digest;
    logic         busy;
    logic         done;
    logic         seq_err;

    sha1_round_core dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .first_block (first_block),
        .w_in        (w_in),
        .round_in    (round_in),
        .w_valid     (w_valid),
        .digest      (digest),
        .busy        (busy),
        .done        (done),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        logic [159:0] dig;
        logic         serr;
        int           cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0]  blk   [16];
    logic [31:0]  sched [80];
    logic [159:0] model_h = IV;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Message expansion straight from the SHA-1 definition.
    task automatic expand();
        logic [31:0] x;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) begin
                sched[t] = blk[t];
            end else begin
                x = sched[t-3] ^ sched[t-8] ^ sched[t-14] ^ sched[t-16];
                sched[t] = {x[30:0], x[31]};
            end
        end
    endtask

    // Reference compression of one block over sched[].
    function automatic logic [159:0] sha1_ref(input logic [159:0] hin);
        logic [31:0] h[5];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 5; i++) h[i] = hin[159-32*i -: 32];
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + sched[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                total_cnt++;
                bad_cnt++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                e = sbq.pop_front();
                check("sb_digest",  digest, e.dig);
                check("sb_seq_err", {159'd0, seq_err}, {159'd0, e.serr});
                check("sb_done_cycle", {128'd0, cyc}, {128'd0, e.cyc});
                check("sb_busy_low", {159'd0, busy}, 160'd0);
            end
        end
    end

    // Action codes: -1 stall, -2 out-of-sequence word, t>=0 word W_t.
    task automatic send_block(input bit first, input int stall_pct, input int bad_at,
                              input int abort_at, input bit noise);
        int acts[$];
        int nw;
        logic [159:0] hin, expd;
        exp_t e;
        expand();
        for (int t = 0; t < 80; t++) begin
            while (stall_pct > 0 && $urandom_range(99) < stall_pct) acts.push_back(-1);
            if (t == bad_at) acts.push_back(-2);
            acts.push_back(t);
        end
        hin  = first ? IV : model_h;
        expd = sha1_ref(hin);
        if (abort_at < 0) model_h = expd;

        start = 1'b1;
        first_block = first;
        w_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy",    {159'd0, busy},    160'd1);
        check("start_seq_err", {159'd0, seq_err}, 160'd0);
        check("start_digest",  digest, hin);
        if (abort_at < 0) begin
            e.dig  = expd;
            e.serr = (bad_at >= 0);
            e.cyc  = cyc + 81 + (acts.size() - 80);
            sbq.push_back(e);
        end

        nw = 0;
        foreach (acts[i]) begin
            if (abort_at >= 0 && nw == abort_at) begin
                w_valid = 1'b0;
                start = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                check("abort_busy",    {159'd0, busy},    160'd0);
                check("abort_done",    {159'd0, done},    160'd0);
                check("abort_seq_err", {159'd0, seq_err}, 160'd0);
                check("abort_digest",  digest, IV);
                reset = 1'b0;
                sbq.delete();
                break;
            end
            if (acts[i] == -1) begin
                w_valid = 1'b0; w_in = $urandom; round_in = 8'($urandom);
            end else if (acts[i] == -2) begin
                w_valid = 1'b1; w_in = $urandom; round_in = 8'(bad_at + 3);
            end else begin
                w_valid = 1'b1; w_in = sched[acts[i]]; round_in = 8'(acts[i] + 2);
            end
            if (noise) begin
                start = ($urandom_range(7) == 0);
                first_block = 1'($urandom);
            end
            @(posedge clk); #1;
            if (acts[i] == -2) check("seq_err_set", {159'd0, seq_err}, 160'd1);
            if (acts[i] >= 0) nw++;
        end
        w_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400; i++) begin
            if (done) return;
            @(posedge clk); #1;
        end
        total_cnt++;
        bad_cnt++;
        $display("FAIL %s_timeout: got no done want done within 400 cycles", nm);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_digest",  digest, IV);
        check("reset_busy",    {159'd0, busy},    160'd0);
        check("reset_done",    {159'd0, done},    160'd0);
        check("reset_seq_err", {159'd0, seq_err}, 160'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // "abc", continuous stream
        load_abc();
        send_block(1'b1, 0, -1, -1, 1'b0);
        wait_done("abc");
        check("kat_abc", digest, 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);
        $display("txn abc digest=%h", digest);

        // empty message
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = 32'h80000000;
        send_block(1'b1, 0, -1, -1, 1'b0);
        wait_done("empty");
        check("kat_empty", digest, 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709);
        $display("txn empty digest=%h", digest);

        // two-block message, second block started on the done cycle
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        send_block(1'b1, 0, -1, -1, 1'b0);
        wait_done("two_block_1");
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[15] = 32'h000001C0;
        send_block(1'b0, 0, -1, -1, 1'b0);
        wait_done("two_block_2");
        check("kat_two_block", digest, 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1);
        $display("txn two_block digest=%h", digest);

        // "abc" with ~30% stalls and ignored start pulses while busy
        load_abc();
        send_block(1'b1, 30, -1, -1, 1'b1);
        wait_done("abc_stall");
        check("kat_abc_stall", digest, 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);
        $display("txn abc_stall digest=%h", digest);

        // out-of-sequence tag 5 at t=2
        send_block(1'b1, 0, 2, -1, 1'b0);
        wait_done("abc_seq");
        check("kat_abc_seq", digest, 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);
        check("seq_err_held", {159'd0, seq_err}, 160'd1);
        $display("txn abc_seq seq_err=%0d", seq_err);

        // reset at t=40 of a chained block, then a clean rerun
        send_block(1'b0, 0, -1, 40, 1'b0);
        $display("txn abort digest=%h busy=%0d", digest, busy);
        send_block(1'b1, 0, -1, -1, 1'b0);
        wait_done("abc_rerun");
        check("kat_abc_rerun", digest, 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);
        $display("txn abc_rerun digest=%h", digest);

        // random blocks, random chaining, stalls and start noise
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            send_block((r == 0) || ($urandom_range(1) == 1), 20, -1, -1, 1'b1);
            wait_done("random");
            $display("txn random %0d digest=%h", r, digest);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", {128'd0, 32'(sbq.size())}, 160'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
